// File: rtl/inst_mem_pipe.sv
// Loadable instruction memory with a RD_LAT-stage registered fetch pipeline and valid/ready on both sides.
// Optional: define INST_MEM_ADDR_CHECK_EN to add the resp_err / sticky load_err range-check outputs.
module inst_mem_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 20,
  parameter int unsigned RD_LAT = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_inst,
  output logic [ADDR_W-1:0] resp_addr,
`ifdef INST_MEM_ADDR_CHECK_EN
  output logic              resp_err,
  output logic              load_err,
`endif
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data
);

  localparam int unsigned     IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q  [DEPTH];
  logic              vld_q  [RD_LAT];
  logic [ADDR_W-1:0] addr_q [RD_LAT];
  logic [DATA_W-1:0] inst_q [RD_LAT];

  logic              stall_c;
  logic              accept_c;
  logic              req_in_range_c;
  logic              load_in_range_c;
  logic [DATA_W-1:0] rd_inst_c;

  // Handshake, range checks and the combinational array read sampled at accept.
  always_comb begin
    stall_c         = vld_q[RD_LAT-1] && !resp_ready;
    req_ready       = !load_en && !stall_c;
    accept_c        = req_valid && !load_en && !stall_c;
    req_in_range_c  = ({1'b0, req_addr} < DEPTH_L);
    load_in_range_c = ({1'b0, load_addr} < DEPTH_L);
    rd_inst_c       = '0;
    if (req_in_range_c) begin
      rd_inst_c = mem_q[IDX_W'(req_addr)];
    end
  end

  // Program storage survives reset; out-of-range loads are dropped.
  always_ff @(posedge clk) begin
    if (load_en && load_in_range_c) begin
      mem_q[IDX_W'(load_addr)] <= load_data;
    end
  end

  // Fetch pipeline: whole pipe holds on stall, bubbles enter stage 0 otherwise.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < int'(RD_LAT); i++) begin
        vld_q[i]  <= 1'b0;
        addr_q[i] <= '0;
        inst_q[i] <= '0;
      end
    end else if (!stall_c) begin
      vld_q[0]  <= accept_c;
      addr_q[0] <= req_addr;
      inst_q[0] <= rd_inst_c;
      for (int i = 1; i < int'(RD_LAT); i++) begin
        vld_q[i]  <= vld_q[i-1];
        addr_q[i] <= addr_q[i-1];
        inst_q[i] <= inst_q[i-1];
      end
    end
  end

  assign resp_valid = vld_q[RD_LAT-1];
  assign resp_addr  = addr_q[RD_LAT-1];
  assign resp_inst  = inst_q[RD_LAT-1];

`ifdef INST_MEM_ADDR_CHECK_EN
  logic err_q [RD_LAT];
  logic load_err_q;

  // Range-error flag travels with its fetch; load error is sticky until reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < int'(RD_LAT); i++) begin
        err_q[i] <= 1'b0;
      end
      load_err_q <= 1'b0;
    end else begin
      if (!stall_c) begin
        err_q[0] <= accept_c && !req_in_range_c;
        for (int i = 1; i < int'(RD_LAT); i++) begin
          err_q[i] <= err_q[i-1];
        end
      end
      if (load_en && !load_in_range_c) begin
        load_err_q <= 1'b1;
      end
    end
  end

  assign resp_err = err_q[RD_LAT-1];
  assign load_err = load_err_q;
`endif

endmodule
